v_fsm_3_rx: RTL and testbench
=============================

Name: v_fsm_3_rx

Overview:
- Receiver for the serial line driven by the three-block FSM transmitter.
- Each 3-cycle frame on the line is: start slot = 1, data slot = x1, stop slot = 0. The line reads 1,1,0 for a 1 and 1,0,0 for a 0.
- The block acquires frame alignment, recovers one data bit per frame, flags framing errors, and packs bits into DATA_W-bit words for the downstream consumer.

Parameters:
- DATA_W, 8: bits per output word, packed MSB-first.
- LOCK_FRAMES, 2: consecutive good frames needed to declare lock (range 1..15).
- ERR_MAX, 2: consecutive bad frames, while locked, that drop lock (range 1..15).

Ports:
- clk  in  1  system clock; line sampled on posedge.
- reset_n  in  1  asynchronous active-low reset.
- din  in  1  serial line from the transmitter, one slot per clk.
- bit_out  out  1  recovered data bit; valid only when bit_valid=1.
- bit_valid  out  1  one-cycle pulse per good frame while locked.
- word_out  out  DATA_W  assembled word; holds its value between word_valid pulses.
- word_valid  out  1  one-cycle pulse when DATA_W bits have been collected.
- locked  out  1  frame alignment acquired.
- frame_err  out  1  one-cycle pulse per bad frame while locked.
- good_cnt  out  16  good-frame count (FRAME_STATS_EN only).
- bad_cnt  out  16  bad-frame count (FRAME_STATS_EN only).

Behaviour:
- Reset: state=HUNT. All outputs are 0, including word_out and both counters. Counters and any partial word are cleared.
- All outputs are registered.
- Hunt states:
  - HUNT: din=1 -> C_D; otherwise stay in HUNT.
  - C_D: latch din as the candidate data bit -> C_Z.
  - C_Z: din=0 -> good-frame count+1. If count reaches LOCK_FRAMES -> L_S with locked=1; otherwise -> C_S. din=1 -> clear count, go to C_D (this 1 is treated as a new start).
  - C_S: din=1 -> C_D. din=0 -> clear count, go to HUNT.
  - No bit_valid, word_valid or frame_err is produced in any hunt state.
- Locked states:
  - Cycle L_S -> L_D -> L_Z -> L_S.
  - L_S samples the start slot.
  - L_D captures the data bit.
  - L_Z samples the stop slot and evaluates the frame.
- Frame evaluation at L_Z:
  - Good frame (start=1 and stop=0): bit_out=data and bit_valid=1 in the cycle after the L_Z sample, i.e. 1 clk after the stop slot. The bad-frame run count is cleared.
  - Bad frame: frame_err=1 in the same cycle position; bit_valid stays 0 and the bit is dropped. The bad-frame run count is incremented.
  - When the run count reaches ERR_MAX: locked=0 in that same cycle, state=HUNT, and the partial word is discarded.
  - A bad frame below ERR_MAX does not disturb slot phase.
- Word packing (locked only):
  - Each good bit shifts in at the LSB.
  - On the DATA_W-th bit, word_out is updated and word_valid pulses in the same cycle as that bit_valid.
  - The bit counter then wraps to 0.
- Reset mid-frame: asynchronous return to HUNT with all outputs 0. There is no resumption of the old phase.
- Alignment is unique: any offset-by-1 or offset-by-2 alignment fails within one frame, so false lock is impossible on a legal stream.

Optional Feature:
- Macro: V_FSM_3_RX_FRAME_STATS_EN.
- Defined:
  - good_cnt increments on every bit_valid.
  - bad_cnt increments on every frame_err.
  - Both saturate at 16'hFFFF and are cleared only by reset.
- Undefined: good_cnt and bad_cnt are tied to 0 and no counter logic is built.

Decomposition:
- Package v_fsm_3_pkg holds:
  - the state encoding (HUNT, C_D, C_Z, C_S, L_S, L_D, L_Z);
  - slot constants START_LVL=1'b1 and STOP_LVL=1'b0;
  - the counter width constant.
- Sub-module v_fsm_3_deser holds the bit-to-word shifter and bit counter.
  - Inputs: bit, bit_valid, flush.
  - Outputs: word_out, word_valid.
  - flush is driven on lock loss.

Test Plan:
- Reset, then drive the line stream for data 1,0,1,1,0,0,1,0 (LOCK_FRAMES=2) -> locked rises after frame 2. Frames 1-2 are consumed by the lock search, so bit_valid reports the data bits of frames 3 onward.
- Lock, then send data 1,0,1,0,0,1,0,1 -> word_valid pulses once with word_out=8'hA5, coincident with the 8th bit_valid.
- While locked, send one frame 1,1,1 (bad stop) -> frame_err pulses once, no bit_valid, locked stays 1. The next good frame decodes normally.
- While locked, send two consecutive bad frames (ERR_MAX=2) -> two frame_err pulses, locked=0 on the second, and partial word discarded. Relock follows within LOCK_FRAMES good frames.
- Start stream at slot offset 1 and offset 2 of the transmitter cycle -> lock acquired at the true frame boundary and the decoded bits match transmitter x1.
- Assert reset_n=0 mid-frame while locked -> all outputs 0 immediately. With the stats macro defined, good_cnt and bad_cnt read 0 after release.

Source files
------------

// File: rtl/v_fsm_3_pkg.sv
// Shared state encoding, slot levels and counter widths for the 3-slot frame receiver.
package v_fsm_3_pkg;

  typedef enum logic [2:0] {
    HUNT,
    C_D,
    C_Z,
    C_S,
    L_S,
    L_D,
    L_Z
  } state_t;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

  // Lock/error run counters cover LOCK_FRAMES and ERR_MAX up to 15.
  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;

endpackage

// File: rtl/v_fsm_3_deser.sv
// Packs recovered bits MSB-first into DATA_W-bit words; flush discards a partial word.
module v_fsm_3_deser #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bit_data,
  input  logic              bit_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid
);

  localparam int BCNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  // Only DATA_W-1 earlier bits need holding; the newest bit joins them at the LSB.
  logic [DATA_W-2:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [BCNT_W-1:0] bcnt_reg;

  assign shift_next = {shift_reg, bit_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      bcnt_reg   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (flush) begin
        shift_reg <= '0;
        bcnt_reg  <= '0;
      end else if (bit_valid) begin
        shift_reg <= shift_next[DATA_W-2:0];
        if (bcnt_reg == BCNT_W'(DATA_W - 1)) begin
          word_out   <= shift_next;
          word_valid <= 1'b1;
          bcnt_reg   <= '0;
        end else begin
          bcnt_reg <= bcnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/v_fsm_3_rx.sv
// Frame-aligning receiver for the 1,x,0 serial line: lock search, bit recovery, word packing.
// Optional frame statistics counters are built when V_FSM_3_RX_FRAME_STATS_EN is defined.
module v_fsm_3_rx
  import v_fsm_3_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LOCK_FRAMES = 2,
  parameter int ERR_MAX     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              din,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              locked,
  output logic              frame_err,
  output logic [STAT_W-1:0] good_cnt,
  output logic [STAT_W-1:0] bad_cnt
);

  state_t           state_reg;
  logic [CNT_W-1:0] hunt_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;
  logic             start_reg;
  logic             data_reg;

  logic frame_eval;
  logic frame_good;
  logic frame_bad;
  logic lock_drop;

  // The stop slot is judged live on din so the outcome registers one clk after it.
  assign frame_eval = (state_reg == L_Z);
  assign frame_good = frame_eval && (start_reg == START_LVL) && (din == STOP_LVL);
  assign frame_bad  = frame_eval && !frame_good;
  assign lock_drop  = frame_bad && (err_cnt_reg == CNT_W'(ERR_MAX - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= HUNT;
      hunt_cnt_reg <= '0;
      err_cnt_reg  <= '0;
      start_reg    <= 1'b0;
      data_reg     <= 1'b0;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      locked       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_reg)
        HUNT: if (din == START_LVL) state_reg <= C_D;
        C_D:  state_reg <= C_Z;
        C_Z: begin
          if (din == STOP_LVL) begin
            if (hunt_cnt_reg == CNT_W'(LOCK_FRAMES - 1)) begin
              hunt_cnt_reg <= '0;
              err_cnt_reg  <= '0;
              locked       <= 1'b1;
              state_reg    <= L_S;
            end else begin
              hunt_cnt_reg <= hunt_cnt_reg + 1'b1;
              state_reg    <= C_S;
            end
          end else begin
            // A high stop slot is taken as the start of a fresh candidate frame.
            hunt_cnt_reg <= '0;
            state_reg    <= C_D;
          end
        end
        C_S: begin
          if (din == START_LVL) begin
            state_reg <= C_D;
          end else begin
            hunt_cnt_reg <= '0;
            state_reg    <= HUNT;
          end
        end
        L_S: begin
          start_reg <= din;
          state_reg <= L_D;
        end
        L_D: begin
          data_reg  <= din;
          state_reg <= L_Z;
        end
        L_Z: begin
          if (frame_good) begin
            bit_out     <= data_reg;
            bit_valid   <= 1'b1;
            err_cnt_reg <= '0;
            state_reg   <= L_S;
          end else begin
            frame_err <= 1'b1;
            if (lock_drop) begin
              err_cnt_reg <= '0;
              locked      <= 1'b0;
              state_reg   <= HUNT;
            end else begin
              err_cnt_reg <= err_cnt_reg + 1'b1;
              state_reg   <= L_S;
            end
          end
        end
        default: state_reg <= HUNT;
      endcase
    end
  end

  v_fsm_3_deser #(
    .DATA_W(DATA_W)
  ) u_deser (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_data  (data_reg),
    .bit_valid (frame_good),
    .flush     (lock_drop),
    .word_out  (word_out),
    .word_valid(word_valid)
  );

`ifdef V_FSM_3_RX_FRAME_STATS_EN
  logic [STAT_W-1:0] good_cnt_reg;
  logic [STAT_W-1:0] bad_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else begin
      if (frame_good && (good_cnt_reg != '1)) good_cnt_reg <= good_cnt_reg + 1'b1;
      if (frame_bad && (bad_cnt_reg != '1))   bad_cnt_reg  <= bad_cnt_reg + 1'b1;
    end
  end

  assign good_cnt = good_cnt_reg;
  assign bad_cnt  = bad_cnt_reg;
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_v_fsm_3_rx.sv
// Bench for v_fsm_3_rx: vector table, offset/reset sequences and a frame-level random model.
module tb_v_fsm_3_rx;

  localparam int DATA_W      = 8;
  localparam int LOCK_FRAMES = 2;
  localparam int ERR_MAX     = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              din = 1'b0;
  logic              bit_out;
  logic              bit_valid;
  logic [DATA_W-1:0] word_out;
  logic              word_valid;
  logic              locked;
  logic              frame_err;
  logic [15:0]       good_cnt;
  logic [15:0]       bad_cnt;

  int   checks = 0;
  int   failures = 0;
  int   stat_good = 0;
  int   stat_bad = 0;
  logic cur_lk = 1'b0;
  int   frame_no = 0;

  typedef struct {
    logic [2:0] slots;  // {start, data, stop}
    logic       bv;
    logic       b;
    logic       fe;
    logic       lk;
    logic       wv;
    logic [7:0] w;
  } vec_t;

  vec_t tbl[$];

  v_fsm_3_rx #(
    .DATA_W(DATA_W),
    .LOCK_FRAMES(LOCK_FRAMES),
    .ERR_MAX(ERR_MAX)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .word_out  (word_out),
    .word_valid(word_valid),
    .locked    (locked),
    .frame_err (frame_err),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_slot(input logic v);
    din = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic bv, input logic b, input logic fe,
                               input logic lk, input logic wv, input logic [7:0] w);
    int exp_g;
    int exp_b;
`ifdef V_FSM_3_RX_FRAME_STATS_EN
    exp_g = stat_good;
    exp_b = stat_bad;
`else
    exp_g = 0;
    exp_b = 0;
`endif
    chk({tag, ".bit_valid"}, bit_valid, bv);
    chk({tag, ".frame_err"}, frame_err, fe);
    chk({tag, ".locked"}, locked, lk);
    chk({tag, ".word_valid"}, word_valid, wv);
    if (bv) chk({tag, ".bit_out"}, bit_out, b);
    if (wv) chk({tag, ".word_out"}, word_out, w);
    chk({tag, ".good_cnt"}, good_cnt, exp_g);
    chk({tag, ".bad_cnt"}, bad_cnt, exp_b);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".bit_out"}, bit_out, 0);
    chk({tag, ".bit_valid"}, bit_valid, 0);
    chk({tag, ".word_out"}, word_out, 0);
    chk({tag, ".word_valid"}, word_valid, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".frame_err"}, frame_err, 0);
    chk({tag, ".good_cnt"}, good_cnt, 0);
    chk({tag, ".bad_cnt"}, bad_cnt, 0);
  endtask

  task automatic do_reset();
    din = 1'b0;
    reset_n = 1'b0;
    stat_good = 0;
    stat_bad = 0;
    cur_lk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
  endtask

  // One frame: pulses are only expected one clk after the stop slot.
  task automatic run_frame(input logic [2:0] slots, input logic bv, input logic b, input logic fe,
                           input logic lk, input logic wv, input logic [7:0] w);
    drive_slot(slots[2]);
    check_outputs("start_slot", 1'b0, 1'b0, 1'b0, cur_lk, 1'b0, 8'h00);
    drive_slot(slots[1]);
    check_outputs("data_slot", 1'b0, 1'b0, 1'b0, cur_lk, 1'b0, 8'h00);
    drive_slot(slots[0]);
    if (bv) stat_good++;
    if (fe) stat_bad++;
    check_outputs("stop_slot", bv, b, fe, lk, wv, w);
    cur_lk = lk;
    $display("frame %0d din=%b bv=%b bit=%b fe=%b lk=%b wv=%b word=%h",
             frame_no, slots, bit_valid, bit_out, frame_err, locked, word_valid, word_out);
    frame_no++;
  endtask

  task automatic add_vec(input logic [2:0] sl, input logic bv, input logic b, input logic fe,
                         input logic lk, input logic wv, input logic [7:0] w);
    vec_t v;
    v.slots = sl; v.bv = bv; v.b = b; v.fe = fe; v.lk = lk; v.wv = wv; v.w = w;
    tbl.push_back(v);
  endtask

  task automatic add_data(input logic d, input logic wv, input logic [7:0] w);
    add_vec({1'b1, d, 1'b0}, 1'b1, d, 1'b0, 1'b1, wv, w);
  endtask

  // Stream joins mid-frame; lock must land on the real stop slot and decode x1 afterwards.
  task automatic offset_test(input int off);
    logic [11:0] data;
    logic        seen;
    int          lock_f;
    int          lock_slot;
    logic        v;
    do_reset();
    if (off == 1) begin
      drive_slot(1'b1);
      drive_slot(1'b0);
    end else begin
      drive_slot(1'b0);
    end
    seen = 1'b0;
    lock_f = -1;
    lock_slot = -1;
    for (int f = 0; f < 12; f++) begin
      data[f] = 1'($urandom_range(0, 1));
      for (int s = 0; s < 3; s++) begin
        v = (s == 0) ? 1'b1 : ((s == 1) ? data[f] : 1'b0);
        drive_slot(v);
        chk($sformatf("off%0d.f%0d.frame_err", off, f), frame_err, 0);
        if (locked && !seen) begin
          seen = 1'b1;
          lock_f = f;
          lock_slot = s;
        end
        if (s == 2 && seen && f > lock_f) begin
          chk($sformatf("off%0d.f%0d.bit_valid", off, f), bit_valid, 1);
          chk($sformatf("off%0d.f%0d.bit_out", off, f), bit_out, data[f]);
        end else begin
          chk($sformatf("off%0d.f%0d.bit_valid", off, f), bit_valid, 0);
        end
      end
      $display("offset %0d frame %0d data=%b locked=%b", off, f, data[f], locked);
    end
    chk($sformatf("off%0d.lock_frame", off), lock_f, LOCK_FRAMES - 1);
    chk($sformatf("off%0d.lock_slot", off), lock_slot, 2);
  endtask

  initial begin
    logic       m_lk;
    int         m_hc;
    int         m_ec;
    logic [7:0] m_acc;
    int         m_n;
    logic       bad;
    int         kind;
    logic       s, d, z;
    logic       e_bv, e_fe, e_wv;
    logic [7:0] e_w;

    // Lock on data 1,0, then 1,1,0,0,1,0,1,0 -> CA.
    add_vec(3'b110, 0, 0, 0, 0, 0, 8'h00);
    add_vec(3'b100, 0, 0, 0, 1, 0, 8'h00);
    add_data(1, 0, 0); add_data(1, 0, 0); add_data(0, 0, 0); add_data(0, 0, 0);
    add_data(1, 0, 0); add_data(0, 0, 0); add_data(1, 0, 0); add_data(0, 1, 8'hCA);
    // 1,0,1,0,0,1,0,1 -> A5.
    add_data(1, 0, 0); add_data(0, 0, 0); add_data(1, 0, 0); add_data(0, 0, 0);
    add_data(0, 0, 0); add_data(1, 0, 0); add_data(0, 0, 0); add_data(1, 1, 8'hA5);
    // Single bad stop, then a good bit that becomes a partial word.
    add_vec(3'b111, 0, 0, 1, 1, 0, 8'h00);
    add_data(1, 0, 0);
    // Two bad frames drop lock and discard the partial bit.
    add_vec(3'b010, 0, 0, 1, 1, 0, 8'h00);
    add_vec(3'b101, 0, 0, 1, 0, 0, 8'h00);
    add_vec(3'b110, 0, 0, 0, 0, 0, 8'h00);
    add_vec(3'b100, 0, 0, 0, 1, 0, 8'h00);
    // 0,1,0,1,1,0,1,0 -> 5A only if the old partial bit was discarded.
    add_data(0, 0, 0); add_data(1, 0, 0); add_data(0, 0, 0); add_data(1, 0, 0);
    add_data(1, 0, 0); add_data(0, 0, 0); add_data(1, 0, 0); add_data(0, 1, 8'h5A);

    do_reset();
    foreach (tbl[i]) run_frame(tbl[i].slots, tbl[i].bv, tbl[i].b, tbl[i].fe,
                               tbl[i].lk, tbl[i].wv, tbl[i].w);

    // Asynchronous reset in the middle of a locked frame.
    drive_slot(1'b1);
    chk("pre_reset.locked", locked, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    stat_good = 0;
    stat_bad = 0;
    cur_lk = 1'b0;
    drive_slot(1'b0);
    check_all_zero("after_release");
    $display("mid-frame reset done locked=%b word=%h", locked, word_out);

    offset_test(1);
    offset_test(2);

    // Randomized frames against a frame-level model; errors only injected while locked.
    do_reset();
    m_lk = 1'b0; m_hc = 0; m_ec = 0; m_acc = 8'h00; m_n = 0;
    for (int f = 0; f < 400; f++) begin
      bad = m_lk && ($urandom_range(0, 5) == 0);
      d = 1'($urandom_range(0, 1));
      s = 1'b1;
      z = 1'b0;
      if (bad) begin
        kind = int'($urandom_range(0, 2));
        s = (kind == 1) ? 1'b1 : 1'b0;
        z = (kind == 0) ? 1'b0 : 1'b1;
      end
      e_bv = 1'b0; e_fe = 1'b0; e_wv = 1'b0; e_w = 8'h00;
      if (!m_lk) begin
        m_hc++;
        if (m_hc == LOCK_FRAMES) begin
          m_lk = 1'b1;
          m_hc = 0;
          m_ec = 0;
        end
      end else if (!bad) begin
        e_bv = 1'b1;
        m_ec = 0;
        m_acc = 8'(m_acc * 2 + d);
        m_n++;
        if (m_n == DATA_W) begin
          e_wv = 1'b1;
          e_w = m_acc;
          m_acc = 8'h00;
          m_n = 0;
        end
      end else begin
        e_fe = 1'b1;
        m_ec++;
        if (m_ec == ERR_MAX) begin
          m_lk = 1'b0;
          m_ec = 0;
          m_acc = 8'h00;
          m_n = 0;
        end
      end
      run_frame({s, d, z}, e_bv, d, e_fe, m_lk, e_wv, e_w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
